// File: rtl/conv1d_sram_pkg.sv
// Shared conv1d SRAM types: request/response bundles,
// arbiter owner tags and arbiter FSM states.
package conv1d_sram_pkg;

   localparam int unsigned SramAddrW = 7;
   localparam int unsigned SramDataW = 32;

   typedef struct packed {
      logic                 req;
      logic                 we;
      logic [SramAddrW-1:0] addr;
      logic [SramDataW-1:0] wdata;
      logic [3:0]           be;
   } sram_req_t;

   typedef struct packed {
      logic                 rvalid;
      logic [SramDataW-1:0] rdata;
   } sram_rsp_t;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_EXT  = 2'd1,
      OWNER_INT  = 2'd2
   } arb_owner_e;

   typedef enum logic {
      HOST  = 1'b0,
      ACCEL = 1'b1
   } arb_state_e;

endpackage

// File: rtl/conv1d_mem_arbiter.sv
// Two-requester arbiter for the single-port conv1d SRAM.
// Host priority when idle, accelerator priority with bounded host stall.
module conv1d_mem_arbiter
   import conv1d_sram_pkg::*;
#(
   parameter int unsigned AddrWidth = 7,
   parameter int unsigned DataWidth = 32,
   parameter int unsigned MaxStall  = 8,
   parameter int unsigned CntWidth  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 acc_busy_i,
   input  logic                 ext_req_i,
   input  logic                 ext_we_i,
   input  logic [AddrWidth-1:0] ext_addr_i,
   input  logic [DataWidth-1:0] ext_wdata_i,
   input  logic [3:0]           ext_be_i,
   output logic                 ext_gnt_o,
   output logic                 ext_rvalid_o,
   output logic [DataWidth-1:0] ext_rdata_o,
   input  logic                 int_req_i,
   input  logic                 int_we_i,
   input  logic [AddrWidth-1:0] int_addr_i,
   input  logic [DataWidth-1:0] int_wdata_i,
   input  logic [3:0]           int_be_i,
   output logic                 int_gnt_o,
   output logic                 int_rvalid_o,
   output logic [DataWidth-1:0] int_rdata_o,
   output logic                 mem_req_o,
   output logic                 mem_we_o,
   output logic [AddrWidth-1:0] mem_addr_o,
   output logic [DataWidth-1:0] mem_wdata_o,
   output logic [3:0]           mem_be_o,
   input  logic [DataWidth-1:0] mem_rdata_i,
   output logic [CntWidth-1:0]  conflict_cnt_o
);

   localparam int unsigned StallW = $clog2(MaxStall + 1);
   localparam logic [StallW-1:0] StallMax = StallW'(MaxStall);

   arb_state_e           state_q, state_d;
   logic [StallW-1:0]    stall_q, stall_d;
   arb_owner_e           owner_q, owner_d;
   logic                 rd_q, rd_d;
   logic [CntWidth-1:0]  cnt_q;
   logic                 sel_ext;
   logic                 ext_gnt, int_gnt;
   logic                 conflict;

   assign conflict = ext_req_i & int_req_i;

   // Arbitration, grants and SRAM request mux.
   always_comb begin
      sel_ext     = 1'b0;
      state_d     = acc_busy_i ? ACCEL : HOST;
      unique case (state_q)
         HOST:    sel_ext = ext_req_i;
         ACCEL:   sel_ext = ext_req_i &
                            (~int_req_i | (stall_q == StallMax));
         default: sel_ext = 1'b0;
      endcase
      ext_gnt     = rst_ni & ext_req_i & sel_ext;
      int_gnt     = rst_ni & int_req_i & ~sel_ext;
      mem_req_o   = ext_gnt | int_gnt;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (ext_gnt) begin
         mem_we_o    = ext_we_i;
         mem_addr_o  = ext_addr_i;
         mem_wdata_o = ext_wdata_i;
         mem_be_o    = ext_be_i;
      end else if (int_gnt) begin
         mem_we_o    = int_we_i;
         mem_addr_o  = int_addr_i;
         mem_wdata_o = int_wdata_i;
         mem_be_o    = int_be_i;
      end
      stall_d = (int_gnt & ext_req_i) ? stall_q + 1'b1 : '0;
      owner_d = ext_gnt ? OWNER_EXT :
                int_gnt ? OWNER_INT : OWNER_NONE;
      rd_d    = mem_req_o & ~mem_we_o;
   end

   assign ext_gnt_o = ext_gnt;
   assign int_gnt_o = int_gnt;

   // Priority state register, follows acc_busy_i one cycle late.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= HOST;
      else         state_q <= state_d;
   end

   // Consecutive host refusals while the accelerator owns memory.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) stall_q <= '0;
      else         stall_q <= stall_d;
   end

   // Response owner and read flag captured at grant.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         owner_q <= OWNER_NONE;
         rd_q    <= 1'b0;
      end else begin
         owner_q <= owner_d;
         rd_q    <= rd_d;
      end
   end

   // Saturating count of cycles with both requesters active.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                      cnt_q <= '0;
      else if (conflict && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
   end

   assign conflict_cnt_o = cnt_q;
   assign ext_rvalid_o   = (owner_q == OWNER_EXT);
   assign int_rvalid_o   = (owner_q == OWNER_INT);
   assign ext_rdata_o    = (ext_rvalid_o & rd_q) ? mem_rdata_i : '0;
   assign int_rdata_o    = (int_rvalid_o & rd_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_conv1d_mem_arbiter.sv
// Directed self-checking bench for conv1d_mem_arbiter.
// Includes a byte-enable SRAM model with one-cycle read latency.
module tb_conv1d_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        acc_busy;
   logic        ext_req, ext_we, int_req, int_we;
   logic [6:0]  ext_addr, int_addr;
   logic [31:0] ext_wdata, int_wdata;
   logic [3:0]  ext_be, int_be;
   logic        ext_gnt, ext_rvalid, int_gnt, int_rvalid;
   logic [31:0] ext_rdata, int_rdata;
   logic        mem_req, mem_we;
   logic [6:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic [3:0]  mem_be;
   logic [15:0] cnt;

   logic        s_ext_gnt, s_ext_rvalid, s_int_gnt, s_int_rvalid;
   logic [31:0] s_ext_rdata, s_int_rdata, s_mem_wdata;
   logic        s_mem_req, s_mem_we;
   logic [6:0]  s_mem_addr;
   logic [3:0]  s_mem_be;
   logic [3:0]  s_cnt;

   logic [31:0] mem [128];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   conv1d_mem_arbiter dut (
      .clk_i(clk), .rst_ni(rst_ni), .acc_busy_i(acc_busy),
      .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
      .ext_wdata_i(ext_wdata), .ext_be_i(ext_be),
      .ext_gnt_o(ext_gnt), .ext_rvalid_o(ext_rvalid),
      .ext_rdata_o(ext_rdata),
      .int_req_i(int_req), .int_we_i(int_we), .int_addr_i(int_addr),
      .int_wdata_i(int_wdata), .int_be_i(int_be),
      .int_gnt_o(int_gnt), .int_rvalid_o(int_rvalid),
      .int_rdata_o(int_rdata),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
      .mem_wdata_o(mem_wdata), .mem_be_o(mem_be),
      .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt)
   );

   conv1d_mem_arbiter #(.CntWidth(4)) sat (
      .clk_i(clk), .rst_ni(rst_ni), .acc_busy_i(acc_busy),
      .ext_req_i(ext_req), .ext_we_i(ext_we), .ext_addr_i(ext_addr),
      .ext_wdata_i(ext_wdata), .ext_be_i(ext_be),
      .ext_gnt_o(s_ext_gnt), .ext_rvalid_o(s_ext_rvalid),
      .ext_rdata_o(s_ext_rdata),
      .int_req_i(int_req), .int_we_i(int_we), .int_addr_i(int_addr),
      .int_wdata_i(int_wdata), .int_be_i(int_be),
      .int_gnt_o(s_int_gnt), .int_rvalid_o(s_int_rvalid),
      .int_rdata_o(s_int_rdata),
      .mem_req_o(s_mem_req), .mem_we_o(s_mem_we),
      .mem_addr_o(s_mem_addr), .mem_wdata_o(s_mem_wdata),
      .mem_be_o(s_mem_be),
      .mem_rdata_i(mem_rdata), .conflict_cnt_o(s_cnt)
   );

   // SRAM model: byte-masked write, registered read.
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp_g;
   logic       prev_int;

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 32'h0;
      mem[5]    = 32'h1111_2222;
      mem[7'h10] = 32'h3333_4444;
      mem_rdata = 32'h0;
      rst_ni = 1'b0; acc_busy = 1'b0;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 7'h05;
      ext_wdata = 32'h0; ext_be = 4'hF;
      int_req = 1'b0; int_we = 1'b0; int_addr = 7'h0;
      int_wdata = 32'h0; int_be = 4'hF;
      #1;
      check("rst_ext_gnt", {31'b0, ext_gnt}, 32'd0);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_rvalid", {30'b0, ext_rvalid, int_rvalid}, 32'd0);
      check("rst_rdata", ext_rdata | int_rdata, 32'd0);
      check("rst_cnt", {16'b0, cnt}, 32'd0);
      ext_req = 1'b0;
      tick(); tick();
      rst_ni = 1'b1;
      #1;
      check("idle_gnt", {30'b0, ext_gnt, int_gnt}, 32'd0);
      check("idle_mem_req", {31'b0, mem_req}, 32'd0);
      check("idle_mem_addr", {25'b0, mem_addr}, 32'd0);

      ext_req = 1'b1; ext_addr = 7'h05;
      int_req = 1'b1; int_addr = 7'h10;
      #1;
      check("host_gnt", {30'b0, ext_gnt, int_gnt}, 32'd2);
      check("host_mem_addr", {25'b0, mem_addr}, 32'h05);
      tick();
      ext_req = 1'b0; int_req = 1'b0;
      #1;
      check("host_ext_rvalid", {31'b0, ext_rvalid}, 32'd1);
      check("host_int_rvalid", {31'b0, int_rvalid}, 32'd0);
      check("host_ext_rdata", ext_rdata, 32'h1111_2222);
      check("host_cnt", {16'b0, cnt}, 32'd1);
      tick();
      check("rvalid_one_cycle", {31'b0, ext_rvalid}, 32'd0);

      ext_req = 1'b1; ext_addr = 7'h05;
      #1;
      check("mid_rst_gnt", {31'b0, ext_gnt}, 32'd1);
      rst_ni = 1'b0;
      ext_req = 1'b0;
      tick();
      check("mid_rst_rvalid", {31'b0, ext_rvalid}, 32'd0);
      check("mid_rst_cnt", {16'b0, cnt}, 32'd0);
      rst_ni = 1'b1;
      tick();
      check("post_rst_rvalid", {30'b0, ext_rvalid, int_rvalid}, 32'd0);

      acc_busy = 1'b1;
      tick();
      ext_req = 1'b1; ext_addr = 7'h01;
      int_req = 1'b1; int_addr = 7'h02;
      prev_int = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         #1;
         exp_g = (c == 9 || c == 18) ? 2'b10 : 2'b01;
         check($sformatf("accel_gnt_c%0d", c),
               {30'b0, ext_gnt, int_gnt}, {30'b0, exp_g});
         if (c > 1)
            check($sformatf("accel_int_rvalid_c%0d", c),
                  {31'b0, int_rvalid}, {31'b0, prev_int});
         prev_int = exp_g[0];
         tick();
      end
      check("accel_cnt", {16'b0, cnt}, 32'd18);
      check("accel_ext_rvalid", {31'b0, ext_rvalid}, 32'd1);

      acc_busy = 1'b0;
      #1;
      check("edge_gnt", {30'b0, ext_gnt, int_gnt}, 32'd1);
      tick();
      check("after_edge_gnt", {30'b0, ext_gnt, int_gnt}, 32'd2);
      tick();
      ext_req = 1'b0; int_req = 1'b0;
      #1;
      check("cnt_20", {16'b0, cnt}, 32'd20);
      check("cnt_sat4", {28'b0, s_cnt}, 32'd15);
      check("nreq_mem_req", {31'b0, mem_req}, 32'd0);
      check("nreq_mem_addr", {25'b0, mem_addr}, 32'd0);
      tick();

      int_req = 1'b1; int_we = 1'b1; int_addr = 7'h7F;
      int_wdata = 32'hDEAD_BEEF; int_be = 4'hF;
      #1;
      check("wr_int_gnt", {30'b0, ext_gnt, int_gnt}, 32'd1);
      check("wr_mem_we", {31'b0, mem_we}, 32'd1);
      check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("wr_mem_addr", {25'b0, mem_addr}, 32'h7F);
      tick();
      int_req = 1'b0; int_we = 1'b0;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 7'h7F;
      #1;
      check("wr_int_rvalid", {31'b0, int_rvalid}, 32'd1);
      check("wr_int_rdata", int_rdata, 32'd0);
      check("rd_ext_gnt", {30'b0, ext_gnt, int_gnt}, 32'd2);
      tick();
      ext_req = 1'b0;
      #1;
      check("rd_ext_rvalid", {31'b0, ext_rvalid}, 32'd1);
      check("rd_int_rvalid", {31'b0, int_rvalid}, 32'd0);
      check("rd_ext_rdata", ext_rdata, 32'hDEAD_BEEF);
      tick();
      check("final_idle", {30'b0, ext_rvalid, int_rvalid}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
